ram_arbiter: RTL and testbench

//  Shares the single-port 16-bit word RAM between two masters (m0 = fetch, m1 = data).

---
 rtl/ram_arbiter.sv | 173 +++++++++++++++++
 tb/tb_ram_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin two-master front end for a single-port, sync-read 16-bit word RAM.
// Optional macro RAM_ARB_RMW_EN: byte writes are merged here by read-modify-write; otherwise byte enables pass to the RAM.
module ram_arbiter #(
  parameter int unsigned DEPTH      = 512,
  parameter bit          FIRST_PRIO = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [1:0]  m0_be,
  input  logic [15:0] m0_addr,
  input  logic [15:0] m0_wdata,
  output logic        m0_ack,
  output logic [15:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [1:0]  m1_be,
  input  logic [15:0] m1_addr,
  input  logic [15:0] m1_wdata,
  output logic        m1_ack,
  output logic [15:0] m1_rdata,
  output logic        busy,
  output logic [15:0] ram_addr,
  output logic [15:0] ram_wdata,
  output logic [1:0]  ram_be,
  output logic        ram_we,
  input  logic [15:0] ram_rdata
);

  typedef enum logic [2:0] {IDLE, RD, CAP, WR, DONE} state_e;

  localparam logic [16:0] DEPTH_W = 17'(DEPTH);

  state_e      state_q, state_d;
  logic        id_q, id_d;
  logic        we_q, we_d;
  logic [1:0]  be_q, be_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        oor_q, oor_d;
  logic        last_q, last_d;
  logic [15:0] res_q, res_d;
  logic [15:0] m0_rdata_q, m0_rdata_d;
  logic [15:0] m1_rdata_q, m1_rdata_d;

  logic        gnt;
  logic        sel_we;
  logic [1:0]  sel_be;
  logic [15:0] sel_addr;
  logic [15:0] sel_wdata;
  logic        sel_oor;
  logic        upd_rdata;

  // Under contention the master that did not win last time goes next.
  assign gnt       = (m0_req && m1_req) ? ~last_q : m1_req;
  assign sel_we    = gnt ? m1_we    : m0_we;
  assign sel_be    = gnt ? m1_be    : m0_be;
  assign sel_addr  = gnt ? m1_addr  : m0_addr;
  assign sel_wdata = gnt ? m1_wdata : m0_wdata;
  assign sel_oor   = {1'b0, sel_addr} >= DEPTH_W;
  assign upd_rdata = !we_q || oor_q;

  always_comb begin
    // NOTE: every *_d is given its hold value first, so no branch can leave one unassigned and infer a latch.
    state_d    = state_q;
    id_d       = id_q;
    we_d       = we_q;
    be_d       = be_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    oor_d      = oor_q;
    last_d     = last_q;
    res_d      = res_q;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          id_d    = gnt;
          we_d    = sel_we;
          be_d    = sel_be;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          oor_d   = sel_oor;
          res_d   = '0;
          if (sel_oor)                state_d = DONE;
          else if (!sel_we)           state_d = RD;
          else if (sel_be == 2'b11)   state_d = WR;
          else if (sel_be == 2'b00)   state_d = DONE;
          else begin
`ifdef RAM_ARB_RMW_EN
            state_d = RD;
`else
            state_d = WR;
`endif
          end
        end
      end
      RD:  state_d = CAP;
      CAP: begin
        if (we_q) begin
          wdata_d = {be_q[1] ? wdata_q[15:8] : ram_rdata[15:8],
                     be_q[0] ? wdata_q[7:0]  : ram_rdata[7:0]};
          state_d = WR;
        end else begin
          unique case (be_q)
            2'b01:   res_d = {8'h00, ram_rdata[7:0]};
            2'b10:   res_d = {8'h00, ram_rdata[15:8]};
            default: res_d = ram_rdata;
          endcase
          state_d = DONE;
        end
      end
      WR:  state_d = DONE;
      DONE: begin
        last_d = id_q;
        if (upd_rdata) begin
          if (id_q) m1_rdata_d = res_q;
          else      m0_rdata_d = res_q;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge value of its neighbours.
    if (rst) begin
      state_q    <= IDLE;
      id_q       <= 1'b0;
      we_q       <= 1'b0;
      be_q       <= 2'b11;
      addr_q     <= '0;
      wdata_q    <= '0;
      oor_q      <= 1'b0;
      last_q     <= ~FIRST_PRIO;
      res_q      <= '0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      id_q       <= id_d;
      we_q       <= we_d;
      be_q       <= be_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      oor_q      <= oor_d;
      last_q     <= last_d;
      res_q      <= res_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
    end
  end

  assign busy      = state_q != IDLE;
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;
  assign ram_we    = state_q == WR;
`ifdef RAM_ARB_RMW_EN
  assign ram_be    = 2'b11;
`else
  assign ram_be    = (state_q == WR) ? be_q : 2'b11;
`endif

  // Read data is forwarded during the ack cycle and held in the per-master register afterwards.
  assign m0_ack   = (state_q == DONE) && !id_q;
  assign m1_ack   = (state_q == DONE) &&  id_q;
  assign m0_rdata = (m0_ack && upd_rdata) ? res_q : m0_rdata_q;
  assign m1_rdata = (m1_ack && upd_rdata) ? res_q : m1_rdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: word RAM model plus a transaction-level reference of memory, latency and arbitration.
module tb_ram_arbiter;

  logic        clk, rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [1:0]  m0_be, m1_be;
  logic [15:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_ack, m1_ack;
  logic [15:0] m0_rdata, m1_rdata;
  logic        busy;
  logic [15:0] ram_addr, ram_wdata, ram_rdata;
  logic [1:0]  ram_be;
  logic        ram_we;

  int vectors;
  int miscompares;

  bit [15:0] mem [512];
  bit [15:0] ref_mem [512];

  bit          op_we [2];
  logic [1:0]  op_be [2];
  logic [15:0] op_addr [2];
  logic [15:0] op_wdata [2];

  ram_arbiter #(.DEPTH(512), .FIRST_PRIO(1'b0)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_be(m0_be), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_be(m1_be), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .busy(busy), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_be(ram_be), .ram_we(ram_we),
    .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // Sync-read RAM honouring byte lanes.
  always @(posedge clk) begin
    if (ram_we) begin
      if (ram_be[0]) mem[ram_addr[8:0]][7:0]  <= ram_wdata[7:0];
      if (ram_be[1]) mem[ram_addr[8:0]][15:8] <= ram_wdata[15:8];
    end
    ram_rdata <= mem[ram_addr[8:0]];
  end

  function automatic logic [15:0] fmt_rd(input logic [15:0] w, input logic [1:0] be);
    if (be == 2'b01)      return {8'h00, w[7:0]};
    else if (be == 2'b10) return {8'h00, w[15:8]};
    else                  return w;
  endfunction

  function automatic logic [15:0] lane_merge(input logic [15:0] old, input logic [15:0] nw, input logic [1:0] be);
    logic [15:0] r;
    r = old;
    if (be[0]) r[7:0]  = nw[7:0];
    if (be[1]) r[15:8] = nw[15:8];
    return r;
  endfunction

  task automatic set_port(input bit m, input bit req, input bit we, input logic [1:0] be,
                          input logic [15:0] addr, input logic [15:0] wdata);
    if (m) begin
      m1_req = req; m1_we = we; m1_be = be; m1_addr = addr; m1_wdata = wdata;
    end else begin
      m0_req = req; m0_we = we; m0_be = be; m0_addr = addr; m0_wdata = wdata;
    end
  endtask

  // One transaction from an idle arbiter; latency counts the grant cycle through the ack cycle.
  task automatic do_txn(input bit m, input bit we, input logic [1:0] be,
                        input logic [15:0] addr, input logic [15:0] wdata, input string tag);
    int lat, exp_lat, we_cnt, exp_we;
    bit got, stray, bad_wr, oor;
    logic [15:0] exp_rd, exp_ramw, seen;
    logic [1:0]  exp_rbe;
    oor = addr >= 16'd512;
    exp_rd = oor ? 16'h0000 : fmt_rd(ref_mem[addr[8:0]], be);
    exp_ramw = wdata;
    exp_rbe  = be;
`ifdef RAM_ARB_RMW_EN
    if (be != 2'b11) exp_ramw = lane_merge(ref_mem[addr[8:0]], wdata, be);
    exp_rbe = 2'b11;
`endif
    if (oor)                  begin exp_lat = 2; exp_we = 0; end
    else if (!we)             begin exp_lat = 4; exp_we = 0; end
    else if (be == 2'b11)     begin exp_lat = 3; exp_we = 1; end
    else if (be == 2'b00)     begin exp_lat = 2; exp_we = 0; end
    else begin
`ifdef RAM_ARB_RMW_EN
      exp_lat = 5;
`else
      exp_lat = 3;
`endif
      exp_we = 1;
    end
    set_port(m, 1'b1, we, be, addr, wdata);
    lat = 0; we_cnt = 0; got = 0; stray = 0; bad_wr = 0;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      if (ram_we) begin
        we_cnt++;
        if (ram_addr !== addr || ram_wdata !== exp_ramw || ram_be !== exp_rbe) bad_wr = 1;
      end
      stray |= m ? m0_ack : m1_ack;
      got = m ? m1_ack : m0_ack;
    end
    seen = m ? m1_rdata : m0_rdata;
    set_port(m, 1'b0, we, be, addr, wdata);
    vectors++;
    if (!got) begin
      miscompares++;
      $display("FAIL %s ack_timeout: no ack within %0d cycles", tag, lat);
    end else if (lat != exp_lat - 1) begin
      miscompares++;
      $display("FAIL %s latency: got %0d cycles, expected %0d", tag, lat + 1, exp_lat);
    end
    vectors++;
    if (we_cnt != exp_we || bad_wr) begin
      miscompares++;
      $display("FAIL %s ram_write: %0d strobes (bad fields=%0d), expected %0d strobes addr=%h data=%h be=%b",
               tag, we_cnt, bad_wr, exp_we, addr, exp_ramw, exp_rbe);
    end
    vectors++;
    if (stray) begin
      miscompares++;
      $display("FAIL %s stray_ack: other master acked", tag);
    end
    if (!we) begin
      vectors++;
      if (seen !== exp_rd) begin
        miscompares++;
        $display("FAIL %s rdata: got %h expected %h", tag, seen, exp_rd);
      end
      @(negedge clk);
      seen = m ? m1_rdata : m0_rdata;
      vectors++;
      if (seen !== exp_rd) begin
        miscompares++;
        $display("FAIL %s rdata_hold: got %h expected %h", tag, seen, exp_rd);
      end
    end else begin
      @(negedge clk);
      if (!oor) ref_mem[addr[8:0]] = lane_merge(ref_mem[addr[8:0]], wdata, be);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    set_port(1'b0, 1'b0, 1'b0, 2'b11, 16'h0, 16'h0);
    set_port(1'b1, 1'b0, 1'b0, 2'b11, 16'h0, 16'h0);
    repeat (3) @(negedge clk);
    vectors++;
    if (m0_ack !== 1'b0 || m1_ack !== 1'b0 || busy !== 1'b0 || ram_we !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: ack0=%b ack1=%b busy=%b ram_we=%b expected all 0", m0_ack, m1_ack, busy, ram_we);
    end
    vectors++;
    if (m0_rdata !== 16'h0 || m1_rdata !== 16'h0 || ram_addr !== 16'h0 || ram_wdata !== 16'h0) begin
      miscompares++;
      $display("FAIL reset_data: rdata0=%h rdata1=%h ram_addr=%h ram_wdata=%h expected all 0",
               m0_rdata, m1_rdata, ram_addr, ram_wdata);
    end
    vectors++;
    if (ram_be !== 2'b11) begin
      miscompares++;
      $display("FAIL reset_be: got %b expected 11", ram_be);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    do_txn(1'b0, 1'b1, 2'b11, 16'd5, 16'hBEEF, "word_write");
    do_txn(1'b0, 1'b0, 2'b11, 16'd5, 16'h0000, "word_read");
    vectors++;
    if (m0_rdata !== 16'hBEEF) begin
      miscompares++;
      $display("FAIL basic_const: got %h expected BEEF", m0_rdata);
    end
  endtask

  task automatic test_byte_write;
    do_txn(1'b1, 1'b1, 2'b11, 16'd7, 16'h1234, "bw_init");
    do_txn(1'b1, 1'b1, 2'b01, 16'd7, 16'h00AB, "bw_low");
    do_txn(1'b1, 1'b1, 2'b10, 16'd7, 16'hCD00, "bw_high");
    do_txn(1'b1, 1'b0, 2'b10, 16'd7, 16'h0000, "bw_read_hi");
    vectors++;
    if (m1_rdata !== 16'h00CD) begin
      miscompares++;
      $display("FAIL bw_const_hi: got %h expected 00CD", m1_rdata);
    end
    do_txn(1'b1, 1'b0, 2'b11, 16'd7, 16'h0000, "bw_read_word");
    vectors++;
    if (m1_rdata !== 16'hCDAB) begin
      miscompares++;
      $display("FAIL bw_const_word: got %h expected CDAB", m1_rdata);
    end
    do_txn(1'b0, 1'b1, 2'b00, 16'd7, 16'hFFFF, "bw_none");
    do_txn(1'b0, 1'b0, 2'b01, 16'd7, 16'h0000, "bw_read_lo");
  endtask

  task automatic test_out_of_range;
    do_txn(1'b0, 1'b1, 2'b11, 16'd88, 16'h7E57, "oor_alias_init");
    do_txn(1'b0, 1'b0, 2'b11, 16'd600, 16'h0000, "oor_read");
    do_txn(1'b0, 1'b1, 2'b11, 16'd600, 16'hDEAD, "oor_write");
    do_txn(1'b1, 1'b0, 2'b11, 16'd88, 16'h0000, "oor_alias_check");
    do_txn(1'b1, 1'b1, 2'b11, 16'd511, 16'hA5A5, "edge_511_write");
    do_txn(1'b1, 1'b0, 2'b11, 16'd511, 16'h0000, "edge_511_read");
    do_txn(1'b1, 1'b0, 2'b11, 16'd512, 16'h0000, "edge_512_read");
  endtask

  task automatic test_reset_mid;
    bit saw_we;
    do_txn(1'b0, 1'b1, 2'b11, 16'd3, 16'h5555, "mid_init");
    saw_we = 0;
    set_port(1'b1, 1'b1, 1'b1, 2'b01, 16'd3, 16'h00AA);
`ifdef RAM_ARB_RMW_EN
    repeat (2) begin
      @(negedge clk);
      saw_we |= ram_we;
    end
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_busy_before: got %b expected 1", busy);
    end
`endif
    rst = 1'b1;
    @(negedge clk);
    saw_we |= ram_we;
    vectors++;
    if (busy !== 1'b0 || m0_ack !== 1'b0 || m1_ack !== 1'b0 || saw_we) begin
      miscompares++;
      $display("FAIL mid_reset: busy=%b ack0=%b ack1=%b ram_we_seen=%b expected all 0", busy, m0_ack, m1_ack, saw_we);
    end
    rst = 1'b0;
    set_port(1'b1, 1'b0, 1'b0, 2'b11, 16'd0, 16'h0);
    @(negedge clk);
    do_txn(1'b0, 1'b0, 2'b11, 16'd3, 16'h0000, "mid_readback");
    vectors++;
    if (m0_rdata !== 16'h5555) begin
      miscompares++;
      $display("FAIL mid_const: got %h expected 5555", m0_rdata);
    end
  endtask

  task automatic test_random;
    logic [15:0] a;
    int sel;
    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0)      a = 16'(512 + $urandom_range(0, 60000));
      else if (sel == 1) a = 16'd511;
      else if (sel == 2) a = 16'd512;
      else               a = 16'($urandom_range(0, 15));
      do_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             a, 16'($urandom), "random");
    end
  endtask

  task automatic new_op(input bit m);
    op_we[m]    = 1'($urandom_range(0, 1));
    op_be[m]    = 2'($urandom_range(0, 3));
    op_addr[m]  = 16'($urandom_range(0, 15));
    op_wdata[m] = 16'($urandom);
    set_port(m, 1'b1, op_we[m], op_be[m], op_addr[m], op_wdata[m]);
  endtask

  // Both masters request from reset; acks must alternate starting with m0.
  task automatic test_contention;
    bit exp_m, m, fail_order, fail_rd, both;
    int acks, cyc;
    logic [15:0] seen;
    rst = 1'b1;
    new_op(1'b0);
    new_op(1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_m = 1'b0; acks = 0; cyc = 0;
    fail_order = 0; fail_rd = 0; both = 0;
    while (acks < 10 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (m0_ack && m1_ack) both = 1;
      else if (m0_ack || m1_ack) begin
        m = m1_ack;
        acks++;
        if (m != exp_m) begin
          fail_order = 1;
          $display("FAIL contention_order: ack %0d went to m%0d expected m%0d", acks, m, exp_m);
        end
        if (!op_we[m]) begin
          seen = m ? m1_rdata : m0_rdata;
          if (seen !== fmt_rd(ref_mem[op_addr[m][8:0]], op_be[m])) begin
            fail_rd = 1;
            $display("FAIL contention_rdata: m%0d got %h expected %h", m, seen,
                     fmt_rd(ref_mem[op_addr[m][8:0]], op_be[m]));
          end
        end else begin
          ref_mem[op_addr[m][8:0]] = lane_merge(ref_mem[op_addr[m][8:0]], op_wdata[m], op_be[m]);
        end
        exp_m = ~m;
        if (acks < 10) new_op(m);
      end
    end
    set_port(1'b0, 1'b0, 1'b0, 2'b11, 16'h0, 16'h0);
    set_port(1'b1, 1'b0, 1'b0, 2'b11, 16'h0, 16'h0);
    vectors++;
    if (acks != 10 || both) begin
      miscompares++;
      $display("FAIL contention_acks: got %0d acks (double=%0d) expected 10", acks, both);
    end
    vectors++;
    if (fail_order) miscompares++;
    vectors++;
    if (fail_rd) miscompares++;
    repeat (6) @(negedge clk);
    do_txn(1'b0, 1'b0, 2'b11, op_addr[0], 16'h0, "post_contention_read");
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    clk = 1'b0;
    test_reset();
    test_basic();
    test_byte_write();
    test_out_of_range();
    test_reset_mid();
    test_random();
    test_contention();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
